spram256x128_arb: RTL and testbench

//  Two-requester arbiter/sequencer for one 256x128 single-port SRAM with active-low byte write enables.

---
 rtl/spram256x128_arb.sv | 169 ++++++++++++++++
 tb/tb_spram256x128_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram256x128_arb.sv
// Round-robin two-port sequencer for a 256x128 single-port SRAM, optional post-reset zero-fill sweep.
// Read latency 1 cycle (2 with SPRAM_ARB_RSP_REG_EN); requests stall on req_ready, responses never stall.
module spram256x128_arb #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 128,
    parameter int BE_W        = DATA_W / 8,
    parameter int INIT_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    input  logic [BE_W-1:0]   p0_req_bweb,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    input  logic [BE_W-1:0]   p1_req_bweb,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              ram_ceb,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic [BE_W-1:0]   ram_bweb,
    input  logic [DATA_W-1:0] ram_q,
    output logic              init_done
);
    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};
    localparam state_t            RST_STATE = (INIT_ON_RST != 0) ? S_INIT : S_RUN;
    localparam logic              RST_DONE  = (INIT_ON_RST != 0) ? 1'b0 : 1'b1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;
    logic              last_gnt_q, last_gnt_d;
    logic              pend_vld_q, pend_port_q;
    logic              run, gnt0, gnt1, rd_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            init_cnt_q  <= '0;
            init_done_q <= RST_DONE;
            last_gnt_q  <= 1'b1;
            pend_vld_q  <= 1'b0;
            pend_port_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            last_gnt_q  <= last_gnt_d;
            pend_vld_q  <= rd_acc;
            pend_port_q <= gnt1;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        last_gnt_d  = last_gnt_q;
        case (state_q)
            S_INIT: begin
                // Counter parks at the last address; the sweep never wraps.
                if (init_cnt_q == CNT_LAST) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: begin
                if (gnt1) begin
                    last_gnt_d = 1'b1;
                end else if (gnt0) begin
                    last_gnt_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        // Gating with rst_n keeps every pin at its idle value while reset is held.
        run      = (state_q == S_RUN) && rst_n;
        gnt0     = run && p0_req_valid && (!p1_req_valid || last_gnt_q);
        gnt1     = run && p1_req_valid && (!p0_req_valid || !last_gnt_q);
        rd_acc   = (gnt0 && !p0_req_we) || (gnt1 && !p1_req_we);
        ram_ceb  = 1'b1;
        ram_web  = 1'b1;
        ram_a    = '0;
        ram_d    = '0;
        ram_bweb = '1;
        if (rst_n && (state_q == S_INIT)) begin
            ram_ceb  = 1'b0;
            ram_web  = 1'b0;
            ram_a    = init_cnt_q;
            ram_bweb = '0;
        end else if (gnt0) begin
            ram_ceb  = 1'b0;
            ram_web  = !p0_req_we;
            ram_a    = p0_req_addr;
            ram_d    = p0_req_wdata;
            ram_bweb = p0_req_we ? p0_req_bweb : '1;
        end else if (gnt1) begin
            ram_ceb  = 1'b0;
            ram_web  = !p1_req_we;
            ram_a    = p1_req_addr;
            ram_d    = p1_req_wdata;
            ram_bweb = p1_req_we ? p1_req_bweb : '1;
        end
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;
    assign init_done    = init_done_q;

`ifdef SPRAM_ARB_RSP_REG_EN
    // Second read-tracking stage: ram_q captured, tag carried alongside.
    logic              rsp0_vld_q, rsp1_vld_q;
    logic [DATA_W-1:0] rsp0_dat_q, rsp1_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            rsp0_dat_q <= '0;
            rsp1_dat_q <= '0;
        end else begin
            rsp0_vld_q <= pend_vld_q && !pend_port_q;
            rsp1_vld_q <= pend_vld_q && pend_port_q;
            if (pend_vld_q && !pend_port_q) rsp0_dat_q <= ram_q;
            if (pend_vld_q && pend_port_q)  rsp1_dat_q <= ram_q;
        end
    end

    assign p0_rsp_valid = rsp0_vld_q;
    assign p1_rsp_valid = rsp1_vld_q;
    assign p0_rsp_rdata = rsp0_dat_q;
    assign p1_rsp_rdata = rsp1_dat_q;
`else
    // ram_q passes straight through on the pulse; hold registers keep the last value otherwise.
    logic [DATA_W-1:0] hold0_q, hold1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            if (pend_vld_q && !pend_port_q) hold0_q <= ram_q;
            if (pend_vld_q && pend_port_q)  hold1_q <= ram_q;
        end
    end

    assign p0_rsp_valid = pend_vld_q && !pend_port_q;
    assign p1_rsp_valid = pend_vld_q && pend_port_q;
    assign p0_rsp_rdata = p0_rsp_valid ? ram_q : hold0_q;
    assign p1_rsp_rdata = p1_rsp_valid ? ram_q : hold1_q;
`endif

endmodule

// File: tb/tb_spram256x128_arb.sv
// Directed bench for spram256x128_arb with a behavioural 256x128 SRAM attached to the ram_* pins.
module tb_spram256x128_arb;
`ifdef SPRAM_ARB_RSP_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam logic [127:0] PAT  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] M10  = 128'hAAAAAAAAAAAAAAAA0706050403020100;
    localparam logic [127:0] D30  = {16{8'h30}};
    localparam logic [127:0] D31  = {16{8'h31}};
    localparam logic [127:0] DEAD = {4{32'hDEADBEEF}};
    localparam logic [127:0] AAS  = {16{8'hAA}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         p0_req_valid = 1'b0, p0_req_we = 1'b0, p1_req_valid = 1'b0, p1_req_we = 1'b0;
    logic [7:0]   p0_req_addr = '0, p1_req_addr = '0;
    logic [127:0] p0_req_wdata = '0, p1_req_wdata = '0;
    logic [15:0]  p0_req_bweb = '1, p1_req_bweb = '1;
    logic         p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
    logic [127:0] p0_rsp_rdata, p1_rsp_rdata;
    logic         ram_ceb, ram_web, init_done;
    logic [7:0]   ram_a;
    logic [127:0] ram_d, ram_q;
    logic [15:0]  ram_bweb;

    int n_cmp = 0, n_err = 0, cyc, n_rsp0 = 0, n_rsp1 = 0;
    int hs0[$], hs1[$];
    logic [127:0] ed0[$], ed1[$];
    logic [127:0] last0 = '0, last1 = '0;
    logic [127:0] mem [256];

    spram256x128_arb dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_bweb(p0_req_bweb),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_bweb(p1_req_bweb),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_a(ram_a), .ram_d(ram_d),
        .ram_bweb(ram_bweb), .ram_q(ram_q), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // SRAM model: Q changes only on a read edge, masked lanes keep old bytes.
    always @(posedge clk) begin
        if (!ram_ceb) begin
            if (!ram_web) begin
                for (int b = 0; b < 16; b++)
                    if (!ram_bweb[b]) mem[ram_a][8*b +: 8] <= ram_d[8*b +: 8];
            end else begin
                ram_q <= mem[ram_a];
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: tags, latency, data, and hold of the idle port's rdata.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_rsp_valid) begin
                n_rsp0++;
                chk("p0_rsp_queued", (hs0.size() != 0 && ed0.size() != 0), 1);
                if (hs0.size() != 0 && ed0.size() != 0) begin
                    chk("p0_rsp_lat", cyc - hs0.pop_front(), RD_LAT);
                    chk("p0_rsp_data", p0_rsp_rdata, ed0.pop_front());
                end
                last0 = p0_rsp_rdata;
                if (!p1_rsp_valid) chk("p1_rdata_hold", p1_rsp_rdata, last1);
            end
            if (p1_rsp_valid) begin
                n_rsp1++;
                chk("p1_rsp_queued", (hs1.size() != 0 && ed1.size() != 0), 1);
                if (hs1.size() != 0 && ed1.size() != 0) begin
                    chk("p1_rsp_lat", cyc - hs1.pop_front(), RD_LAT);
                    chk("p1_rsp_data", p1_rsp_rdata, ed1.pop_front());
                end
                last1 = p1_rsp_rdata;
                if (!p0_rsp_valid) chk("p0_rdata_hold", p0_rsp_rdata, last0);
            end
            if (p0_req_valid && p0_req_ready && !p0_req_we) hs0.push_back(cyc);
            if (p1_req_valid && p1_req_ready && !p1_req_we) hs1.push_back(cyc);
        end
    end

    task automatic set_req(input bit port, input bit v, input bit we, input logic [7:0] a,
                           input logic [127:0] d, input logic [15:0] b);
        if (!port) begin
            p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d; p0_req_bweb = b;
        end else begin
            p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d; p1_req_bweb = b;
        end
    endtask

    // Called just after a posedge; holds the request until accepted (bounded).
    task automatic issue(input bit port, input bit we, input logic [7:0] a,
                         input logic [127:0] d, input logic [15:0] b);
        int n;
        set_req(port, 1'b1, we, a, d, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? p1_req_ready : p0_req_ready) && n < 16);
        chk("issue_ready", port ? p1_req_ready : p0_req_ready, 1'b1);
        @(posedge clk); #1;
        if (!port) p0_req_valid = 1'b0; else p1_req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (RD_LAT + 2) begin
            @(negedge clk);
            chk("idle_pins", {ram_ceb, ram_web}, 2'b11);
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_ctl"}, {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid,
                            ram_ceb, ram_web, init_done}, 7'b0000110);
        chk({tag, "_rd0"}, p0_rsp_rdata, '0);
        chk({tag, "_rd1"}, p1_rsp_rdata, '0);
    endtask

    task automatic flush();
        hs0.delete(); hs1.delete(); ed0.delete(); ed1.delete();
        last0 = '0; last1 = '0;
    endtask

    // Starts just after the releasing posedge; returns at the negedge of cycle n-1.
    task automatic sweep_chk(input int n);
        logic [7:0] k8;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            k8 = k[7:0];
            chk("init_sweep", {ram_ceb, ram_web, p0_req_ready, p1_req_ready, init_done,
                               |ram_d, |ram_bweb, ram_a}, {7'b0, k8});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]   t3a0 [4], t3a1 [4];
        logic [127:0] t3e0 [4], t3e1 [4];
        int b0, b1, i0, i1;
        logic g0, g1;

        // T1: reset values with both ports requesting, then the full sweep
        set_req(0, 1, 0, 8'hA5, '0, '1);
        set_req(1, 1, 0, 8'hA5, '0, '1);
        repeat (3) @(posedge clk);
        #1 reset_chk("rst");
        ed0.push_back('0);
        ed1.push_back('0);
        rst_n = 1'b1;
        sweep_chk(256);
        @(negedge clk);
        chk("t1_init_done", init_done, 1'b1);
        chk("t1_gnt_first", {p0_req_ready, p1_req_ready}, 2'b10);
        @(posedge clk); #1 p0_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_gnt_second", {p0_req_ready, p1_req_ready}, 2'b01);
        @(posedge clk); #1 p1_req_valid = 1'b0;
        drain();

        // T2: byte-lane writes
        issue(0, 1, 8'h10, PAT, 16'hFFFE);
        ed0.push_back('0);
        issue(0, 0, 8'h10, '0, '1);
        issue(0, 1, 8'h10, PAT, 16'h0000);
        ed0.push_back(PAT);
        issue(0, 0, 8'h10, '0, '1);
        issue(0, 1, 8'h10, AAS, 16'h00FF);
        ed0.push_back(M10);
        issue(0, 0, 8'h10, '0, '1);
        drain();

        // T3: continuous contention, p1 handshaked last so p0 goes first
        issue(0, 1, 8'h30, D30, 16'h0000);
        issue(1, 1, 8'h31, D31, 16'h0000);
        t3a0 = '{8'h30, 8'h10, 8'h30, 8'h10};
        t3e0 = '{D30, M10, D30, M10};
        t3a1 = '{8'h31, 8'hA5, 8'h31, 8'hA5};
        t3e1 = '{D31, 128'h0, D31, 128'h0};
        for (int j = 0; j < 4; j++) begin
            ed0.push_back(t3e0[j]);
            ed1.push_back(t3e1[j]);
        end
        b0 = n_rsp0; b1 = n_rsp1; i0 = 0; i1 = 0;
        set_req(0, 1, 0, t3a0[0], '0, '1);
        set_req(1, 1, 0, t3a1[0], '0, '1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g0 = p0_req_ready;
            g1 = p1_req_ready;
            chk("t3_gnt", {g0, g1}, (c % 2 == 0) ? 2'b10 : 2'b01);
            chk("t3_addr", ram_a, g0 ? t3a0[i0] : t3a1[i1]);
            @(posedge clk); #1;
            if (g0) begin
                i0++;
                if (i0 < 4) set_req(0, 1, 0, t3a0[i0], '0, '1); else p0_req_valid = 1'b0;
            end
            if (g1) begin
                i1++;
                if (i1 < 4) set_req(1, 1, 0, t3a1[i1], '0, '1); else p1_req_valid = 1'b0;
            end
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        drain();
        chk("t3_p0_pulses", n_rsp0 - b0, 4);
        chk("t3_p1_pulses", n_rsp1 - b1, 4);

        // T4: read-after-write back to back on p1
        issue(1, 1, 8'hFF, DEAD, 16'h0000);
        ed1.push_back(DEAD);
        issue(1, 0, 8'hFF, '0, '1);
        drain();

        // T5: p1 held while p0 wins; read forces bweb high despite a zero field
        b0 = n_rsp0; b1 = n_rsp1;
        ed0.push_back(D30);
        ed1.push_back(DEAD);
        set_req(0, 1, 0, 8'h30, '0, 16'h0000);
        set_req(1, 1, 0, 8'hFF, '0, 16'h0000);
        @(negedge clk);
        chk("t5_gnt_p0", {p0_req_ready, p1_req_ready}, 2'b10);
        chk("t5_pins_p0", {ram_ceb, ram_web, ram_bweb, ram_a}, {2'b01, 16'hFFFF, 8'h30});
        @(posedge clk); #1 p0_req_valid = 1'b0;
        @(negedge clk);
        chk("t5_gnt_p1", {p0_req_ready, p1_req_ready}, 2'b01);
        chk("t5_pins_p1", {ram_ceb, ram_web, ram_a}, {2'b01, 8'hFF});
        @(posedge clk); #1 p1_req_valid = 1'b0;
        drain();
        chk("t5_p0_pulses", n_rsp0 - b0, 1);
        chk("t5_p1_pulses", n_rsp1 - b1, 1);

        // T6a: reset lands on a pending read
        set_req(0, 1, 0, 8'h31, '0, '1);
        @(negedge clk);
        chk("t6_rd_ready", p0_req_ready, 1'b1);
        @(posedge clk);
        rst_n = 1'b0;
        #1 reset_chk("t6_rd");
        flush();
        p0_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // T6b: reset at sweep count 100, sweep restarts from 0 and re-zeroes the array
        sweep_chk(101);
        rst_n = 1'b0;
        #1 reset_chk("t6_sweep");
        flush();
        @(posedge clk);
        #1 rst_n = 1'b1;
        sweep_chk(256);
        @(negedge clk);
        chk("t6_init_done", init_done, 1'b1);
        @(posedge clk); #1;
        ed0.push_back('0);
        issue(0, 0, 8'h30, '0, '1);
        ed1.push_back('0);
        issue(1, 0, 8'hFF, '0, '1);
        drain();

        chk("end_p0_queue", hs0.size() + ed0.size(), 0);
        chk("end_p1_queue", hs1.size() + ed1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
